// File: rtl/rv32_pkg.sv
// Shared decode constants and types for the RV32 operand-fetch slice.
// Opcode map, immediate formats and per-opcode operand usage.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_cls;
        logic illegal;
        imm_t imm_type;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d = '{use_rs1: 1'b0, use_rs2: 1'b0, wr_cls: 1'b0,
              illegal: 1'b0, imm_type: IMM_NONE};
        unique case (op)
            OP_R: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.wr_cls  = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                d.use_rs1  = 1'b1;
                d.wr_cls   = 1'b1;
                d.imm_type = IMM_I;
            end
            OP_STORE: begin
                d.use_rs1  = 1'b1;
                d.use_rs2  = 1'b1;
                d.imm_type = IMM_S;
            end
            OP_BRANCH: begin
                d.use_rs1  = 1'b1;
                d.use_rs2  = 1'b1;
                d.imm_type = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                d.wr_cls   = 1'b1;
                d.imm_type = IMM_U;
            end
            OP_JAL: begin
                d.wr_cls   = 1'b1;
                d.imm_type = IMM_J;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate extraction for the RV32I formats, sign-extended to XLEN.
// Opcode bits are not needed here, so only instr[31:7] is taken.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_t            imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_NONE: imm = '0;
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_operand_fetch.sv
// Decode / operand-fetch stage: RF read, writeback bypass, pending-write
// scoreboard and the output register feeding the ALU stage.
module rv32_operand_fetch
    import rv32_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [ADDR_W-1:0] rs1_address,
    output logic [ADDR_W-1:0] rs2_address,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_enable,
    input  logic [ADDR_W-1:0] wb_address,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [ADDR_W-1:0] out_rd,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic              out_wr_rd,
    output logic              out_illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    dec_t              dec;
    logic              wr_rd;
    logic [XLEN-1:0]   imm;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign dec    = decode(opcode);
    assign wr_rd  = dec.wr_cls && (rd != '0);

    assign rs1_address = rs1;
    assign rs2_address = rs2;

    rv32_imm_gen u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (dec.imm_type),
        .imm      (imm)
    );

    logic              hit1;
    logic              hit2;
    logic              hitd;
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pend_nxt;
    logic              hazard;
    logic              issue;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

    // A writeback landing this cycle retires the pending bit in time.
    assign hit1 = wb_enable && (wb_address == rs1) && (rs1 != '0);
    assign hit2 = wb_enable && (wb_address == rs2) && (rs2 != '0);
    assign hitd = wb_enable && (wb_address == rd) && (rd != '0);

    assign hazard =
        (dec.use_rs1 && (rs1 != '0) && pending[rs1] && !hit1) ||
        (dec.use_rs2 && (rs2 != '0) && pending[rs2] && !hit2) ||
        (wr_rd && pending[rd] && !hitd);

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    // RF write is synchronous, so its read still shows the old value.
    assign rs1_val = (rs1 == '0) ? '0 : (hit1 ? wb_data : rs1_data);
    assign rs2_val = (rs2 == '0) ? '0 : (hit2 ? wb_data : rs2_data);

    always_comb begin
        pend_nxt = pending;
        if (wb_enable)
            pend_nxt[wb_address] = 1'b0;
        if (flush && out_valid && out_wr_rd)
            pend_nxt[out_rd] = 1'b0;
        if (issue && wr_rd)
            pend_nxt[rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending     <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_wr_rd   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (issue) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_rs1_val <= rs1_val;
                out_rs2_val <= rs2_val;
                out_imm     <= imm;
                out_rd      <= rd;
                out_opcode  <= opcode;
                out_funct3  <= funct3;
                out_funct7  <= funct7;
                out_wr_rd   <= wr_rd;
                out_illegal <= dec.illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_operand_fetch.sv
// Self-checking bench for rv32_operand_fetch: vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_rv32_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_enable;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_wr_rd;
    logic        out_illegal;

    always #5 clock = ~clock;

    rv32_operand_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .rs1_address (rs1_address),
        .rs2_address (rs2_address),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_enable   (wb_enable),
        .wb_address  (wb_address),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_imm     (out_imm),
        .out_rd      (out_rd),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_wr_rd   (out_wr_rd),
        .out_illegal (out_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural view of the output slot and the
    // set of registers with an outstanding write.
    bit          m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    bit          m_wr, m_ill;
    bit          m_pend [32];

    typedef struct {
        bit          u1;
        bit          u2;
        bit          wrc;
        bit          ill;
        logic [31:0] imm;
    } mdec_t;

    function automatic mdec_t mdecode(input logic [31:0] i);
        mdec_t d;
        logic [31:0] ni, ns, nb, nu, nj;
        ni = (i[31] ? 32'hFFFFF800 : 32'h0) + 32'(i[30:20]);
        ns = (i[31] ? 32'hFFFFF800 : 32'h0) + (32'(i[30:25]) << 5)
             + 32'(i[11:7]);
        nb = (i[31] ? 32'hFFFFF000 : 32'h0) + (32'(i[7]) << 11)
             + (32'(i[30:25]) << 5) + (32'(i[11:8]) << 1);
        nu = i & 32'hFFFFF000;
        nj = (i[31] ? 32'hFFF00000 : 32'h0) + (32'(i[19:12]) << 12)
             + (32'(i[20]) << 11) + (32'(i[30:21]) << 1);
        d = '{u1: 0, u2: 0, wrc: 0, ill: 0, imm: 32'h0};
        case (i[6:0])
            7'h33:              begin d.u1 = 1; d.u2 = 1; d.wrc = 1; end
            7'h13, 7'h03, 7'h67: begin d.u1 = 1; d.wrc = 1; d.imm = ni; end
            7'h23:              begin d.u1 = 1; d.u2 = 1; d.imm = ns; end
            7'h63:              begin d.u1 = 1; d.u2 = 1; d.imm = nb; end
            7'h37, 7'h17:       begin d.wrc = 1; d.imm = nu; end
            7'h6F:              begin d.wrc = 1; d.imm = nj; end
            default:            d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic bit mhit(input logic [4:0] a);
        return wb_enable && wb_address == a && a != 0;
    endfunction

    function automatic logic [31:0] mpend_word();
        logic [31:0] w;
        for (int k = 0; k < 32; k++) w[k] = m_pend[k];
        return w;
    endfunction

    function automatic bit mready();
        mdec_t d;
        logic [4:0] a1, a2, ad;
        bit hz;
        d  = mdecode(in_instr);
        a1 = in_instr[19:15];
        a2 = in_instr[24:20];
        ad = in_instr[11:7];
        hz = (d.u1 && a1 != 0 && m_pend[a1] && !mhit(a1)) ||
             (d.u2 && a2 != 0 && m_pend[a2] && !mhit(a2)) ||
             (d.wrc && ad != 0 && m_pend[ad] && !mhit(ad));
        return !flush && !hz && (!m_valid || out_ready);
    endfunction

    task automatic mupdate();
        mdec_t d;
        bit iss;
        logic [4:0] a1, a2, ad;
        if (reset) begin
            m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
            m_rd = 0; m_op = 0; m_f3 = 0; m_f7 = 0; m_wr = 0; m_ill = 0;
            foreach (m_pend[k]) m_pend[k] = 0;
            return;
        end
        d   = mdecode(in_instr);
        a1  = in_instr[19:15];
        a2  = in_instr[24:20];
        ad  = in_instr[11:7];
        iss = in_valid && mready();
        if (wb_enable) m_pend[wb_address] = 0;
        if (flush && m_valid && m_wr) m_pend[m_rd] = 0;
        if (iss && d.wrc && ad != 0) m_pend[ad] = 1;
        m_pend[0] = 0;
        if (flush) begin
            m_valid = 0;
        end else if (iss) begin
            m_valid = 1;
            m_pc  = in_pc;
            m_rs1 = (a1 == 0) ? 0 : (mhit(a1) ? wb_data : rs1_data);
            m_rs2 = (a2 == 0) ? 0 : (mhit(a2) ? wb_data : rs2_data);
            m_imm = d.imm;
            m_rd  = ad;
            m_op  = in_instr[6:0];
            m_f3  = in_instr[14:12];
            m_f7  = in_instr[31:25];
            m_wr  = d.wrc && ad != 0;
            m_ill = d.ill;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("rnd_in_ready", in_ready, mready());
        chk("rnd_out_valid", out_valid, m_valid);
        chk("rnd_pending", dut.pending, mpend_word());
        if (m_valid) begin
            chk("rnd_pc", out_pc, m_pc);
            chk("rnd_rs1", out_rs1_val, m_rs1);
            chk("rnd_rs2", out_rs2_val, m_rs2);
            chk("rnd_imm", out_imm, m_imm);
            chk("rnd_rd", out_rd, m_rd);
            chk("rnd_fields", {out_opcode, out_funct3, out_funct7},
                {m_op, m_f3, m_f7});
            chk("rnd_wr_ill", {out_wr_rd, out_illegal}, {m_wr, m_ill});
        end
    endtask

    // One clock: optional compare at negedge, model update, then the edge.
    task automatic step(input bit do_cmp);
        @(negedge clock);
        if (do_cmp) compare_all();
        mupdate();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] i,
                         input logic [31:0] pc);
        in_valid = v;
        in_instr = i;
        in_pc    = pc;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          wr;
        bit          ill;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [31:0] hold_pc;
        logic [31:0] e1, e2;
        logic [31:0] ops [10];

        tbl[0] = '{32'h00700293, 32'h00000007, 5'd5, 1, 0};
        tbl[1] = '{32'hFFF10093, 32'hFFFFFFFF, 5'd1, 1, 0};
        tbl[2] = '{32'h002081B3, 32'h00000000, 5'd3, 1, 0};
        tbl[3] = '{32'h0020A423, 32'h00000008, 5'd8, 0, 0};
        tbl[4] = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd29, 0, 0};
        tbl[5] = '{32'h123454B7, 32'h12345000, 5'd9, 1, 0};
        tbl[6] = '{32'h001000EF, 32'h00000800, 5'd1, 1, 0};
        tbl[7] = '{32'h0000007F, 32'h00000000, 5'd0, 0, 1};
        tbl[8] = '{32'h00008067, 32'h00000000, 5'd0, 0, 0};

        reset = 1; flush = 0; out_ready = 1;
        drive(0, 32'h0, 32'h0);
        rs1_data = 0; rs2_data = 0;
        wb_enable = 0; wb_address = 0; wb_data = 0;
        step(0);
        step(0);
        reset = 0;
        #1;

        // Reset state and first issue
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_pending", dut.pending, 0);
        chk("rst_in_ready", in_ready, 1);
        drive(1, 32'h00700293, 32'h0);
        step(0);
        chk("t1_valid", out_valid, 1);
        chk("t1_imm", out_imm, 7);
        chk("t1_rd", out_rd, 5);
        chk("t1_wr_rd", out_wr_rd, 1);
        chk("t1_pend5", dut.pending[5], 1);

        // RAW stall resolved by same-cycle writeback
        drive(1, 32'h00528333, 32'h4);
        #1;
        chk("t2_stall", in_ready, 0);
        wb_enable = 1; wb_address = 5; wb_data = 32'h1234;
        #1;
        chk("t2_ready", in_ready, 1);
        step(0);
        chk("t2_rs1", out_rs1_val, 32'h1234);
        chk("t2_rs2", out_rs2_val, 32'h1234);
        chk("t2_rd", out_rd, 6);
        chk("t2_pend5", dut.pending[5], 0);
        chk("t2_pend6", dut.pending[6], 1);

        // Bypass beats stale RF data
        drive(1, 32'h004183B3, 32'h8);
        rs1_data = 32'hDEAD; rs2_data = 32'h5555;
        wb_address = 3; wb_data = 32'hBEEF;
        step(0);
        wb_enable = 0;
        chk("t3_rs1", out_rs1_val, 32'hBEEF);
        chk("t3_rs2", out_rs2_val, 32'h5555);

        // Backpressure holds the output slot
        out_ready = 0;
        drive(1, 32'h123454B7, 32'h100);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_in_ready", in_ready, 0);
            step(0);
            chk("t4_pc_hold", out_pc, 32'h8);
            chk("t4_rd_hold", out_rd, 7);
        end
        out_ready = 1;
        #1;
        chk("t4_release", in_ready, 1);
        step(0);
        chk("t4_pc_new", out_pc, 32'h100);
        chk("t4_rd_new", out_rd, 9);
        chk("t4_pend9", dut.pending[9], 1);

        // Flush kills the held lui and its pending bit
        out_ready = 0;
        drive(1, 32'h00100513, 32'h104);
        flush = 1;
        #1;
        chk("t5_in_ready", in_ready, 0);
        step(0);
        flush = 0;
        chk("t5_valid", out_valid, 0);
        chk("t5_pend9", dut.pending[9], 0);
        chk("t5_pend10", dut.pending[10], 0);

        // x0 destination and illegal opcode
        out_ready = 1;
        drive(1, 32'h00100013, 32'h108);
        step(0);
        chk("t6_x0_valid", out_valid, 1);
        chk("t6_x0_wr", out_wr_rd, 0);
        chk("t6_x0_pend", dut.pending[0], 0);
        drive(1, 32'h0003807F, 32'h10C);
        #1;
        chk("t6_ill_ready", in_ready, 1);
        step(0);
        chk("t6_ill", out_illegal, 1);
        chk("t6_ill_wr", out_wr_rd, 0);

        // Reset in the middle of a stall
        drive(1, 32'h00738333, 32'h110);
        #1;
        chk("t6_stall", in_ready, 0);
        step(0);
        reset = 1;
        step(0);
        reset = 0;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_pend", dut.pending, 0);

        // Decode vector table, each from a clean reset
        rs1_data = 32'hA1A1A1A1;
        rs2_data = 32'hB2B2B2B2;
        for (int k = 0; k < 9; k++) begin
            reset = 1;
            step(0);
            reset = 0;
            drive(1, tbl[k].instr, 32'h200 + 32'(k));
            step(0);
            in_valid = 0;
            e1 = (tbl[k].instr[19:15] == 0) ? 32'h0 : rs1_data;
            e2 = (tbl[k].instr[24:20] == 0) ? 32'h0 : rs2_data;
            chk("vec_valid", out_valid, 1);
            chk("vec_imm", out_imm, tbl[k].imm);
            chk("vec_rd", out_rd, tbl[k].rd);
            chk("vec_wr", out_wr_rd, tbl[k].wr);
            chk("vec_ill", out_illegal, tbl[k].ill);
            chk("vec_rs1", out_rs1_val, e1);
            chk("vec_rs2", out_rs2_val, e2);
            chk("vec_pc", out_pc, 32'h200 + 32'(k));
        end

        // Randomized run against the model
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        reset = 1;
        step(0);
        reset = 0;
        for (int n = 0; n < 600; n++) begin
            in_instr   = {7'($urandom), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 3'($urandom),
                          5'($urandom_range(0, 3)),
                          ops[$urandom_range(0, 9)][6:0]};
            in_valid   = ($urandom_range(0, 3) != 0);
            in_pc      = $urandom;
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            wb_enable  = ($urandom_range(0, 2) == 0);
            wb_address = 5'($urandom_range(0, 3));
            wb_data    = $urandom;
            flush      = ($urandom_range(0, 11) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 99) == 0);
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
